// File: rtl/stepper_motion_seq.sv
// Motion-command stage ahead of the stepper driver: turns absolute targets into start/dir/pulses
// moves and tracks the absolute position. Define SOFT_LIMIT_EN to clamp targets to soft limits.

module stepper_motion_seq #(
  parameter int unsigned               POS_W        = 24,
  parameter int unsigned               BUSY_TIMEOUT = 16,
  // Defaults are the most negative / most positive POS_W-bit values.
  parameter logic signed [POS_W-1:0]   SOFT_MIN     = {1'b1, {(POS_W-1){1'b0}}},
  parameter logic signed [POS_W-1:0]   SOFT_MAX     = {1'b0, {(POS_W-1){1'b1}}}
) (
  input  logic             i_clk_100k,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [POS_W-1:0] i_cmd_target,
  input  logic             i_zero,
  output logic             o_start,
  output logic             o_dir,
  output logic [POS_W-1:0] o_pulses,
  input  logic             i_drv_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [POS_W-1:0] o_position,
  output logic             o_moving
);

  localparam int unsigned     CntW     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  tgt_q, tgt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  pulses_q, pulses_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [POS_W-1:0]  eff_tgt;
  logic [POS_W:0]    diff;
  logic [POS_W-1:0]  mag;
  logic [CntW-1:0]   cnt_inc;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] t);
    if ($signed(t) < SOFT_MIN) return SOFT_MIN;
    if ($signed(t) > SOFT_MAX) return SOFT_MAX;
    return t;
  endfunction

`ifdef SOFT_LIMIT_EN
  assign eff_tgt = clamp_pos(tgt_q);
`else
  assign eff_tgt = tgt_q;
`endif

  // One extra bit so the full span between extremes is representable.
  assign diff    = {eff_tgt[POS_W-1], eff_tgt} - {pos_q[POS_W-1], pos_q};
  assign mag     = diff[POS_W] ? (~diff[POS_W-1:0] + POS_W'(1)) : diff[POS_W-1:0];
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    pos_d    = pos_q;
    pulses_d = pulses_q;
    dir_d    = dir_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          tgt_d   = i_cmd_target;
          err_d   = 1'b0;
          state_d = StCalc;
        end else if (i_zero) begin
          pos_d = '0;
        end
      end
      StCalc: begin
        tgt_d    = eff_tgt;
        dir_d    = ~diff[POS_W] && (diff != '0);
        pulses_d = mag;
        if (diff == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (i_drv_busy) begin
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntLimit) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWaitDone: begin
        if (!i_drv_busy) begin
          pos_d   = tgt_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_100k) begin
    if (i_rst) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      pos_q    <= '0;
      pulses_q <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      pos_q    <= pos_d;
      pulses_q <= pulses_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      start_q  <= start_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_cmd_ready = (state_q == StIdle);
  assign o_moving    = (state_q != StIdle);
  assign o_start     = start_q;
  assign o_dir       = dir_q;
  assign o_pulses    = pulses_q;
  assign o_done      = done_q;
  assign o_error     = err_q;
  assign o_position  = pos_q;

endmodule

// File: tb/tb_stepper_motion_seq.sv
// Bench for stepper_motion_seq: event-schedule model of each move plus literal spot checks.
// Honours SOFT_LIMIT_EN to match the design build.

module tb_stepper_motion_seq;

  localparam int POS_W = 24;
  localparam int BT    = 16;
  localparam int SMIN  = -8388608;
  localparam int SMAX  = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [POS_W-1:0]  cmd_target;
  logic              zero;
  logic              start;
  logic              dir;
  logic [POS_W-1:0]  pulses;
  logic              drv_busy;
  logic              done;
  logic              error;
  logic [POS_W-1:0]  position;
  logic              moving;

  stepper_motion_seq #(
    .POS_W        (POS_W),
    .BUSY_TIMEOUT (BT),
    .SOFT_MIN     (24'(SMIN)),
    .SOFT_MAX     (24'(SMAX))
  ) dut (
    .i_clk_100k   (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_target (cmd_target),
    .i_zero       (zero),
    .o_start      (start),
    .o_dir        (dir),
    .o_pulses     (pulses),
    .i_drv_busy   (drv_busy),
    .o_done       (done),
    .o_error      (error),
    .o_position   (position),
    .o_moving     (moving)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: expected position/error plus the cycle schedule of the move in flight.
  int m_pos = 0, m_pulses = 0;
  bit m_err = 1'b0, m_dir = 1'b0, check_en = 1'b0, mv;
  int m_a = -100, m_start = -1, m_done = -1, m_end = -100;
  int m_upd_cyc = -1, m_upd_val = 0, m_eclr = -1, m_eset = -1;
  int n_start = 0;
  logic [POS_W-1:0] cap_pulses = '0;
  logic             cap_dir = 1'b0;

  // Driver model: busy rises dly+1 cycles after o_start and stays high len cycles (len 0: never).
  int drv_s = -1000, drv_dly = 0, drv_len = 0;
  always @(negedge clk) if (start) drv_s = cyc;
  initial begin
    drv_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      drv_busy = (drv_len > 0) && (cyc >= drv_s + 1 + drv_dly) &&
                 (cyc < drv_s + 1 + drv_dly + drv_len);
    end
  end

  function automatic int clampv(input int t);
`ifdef SOFT_LIMIT_EN
    if (t > SMAX) return SMAX;
    if (t < SMIN) return SMIN;
`endif
    return t;
  endfunction

  always @(negedge clk) begin
    if (cyc == m_upd_cyc) m_pos = m_upd_val;
    if (cyc == m_eclr) m_err = 1'b0;
    if (cyc == m_eset) m_err = 1'b1;
    if (start) begin
      n_start++;
      cap_pulses = pulses;
      cap_dir    = dir;
    end
    if (check_en) begin
      mv = (cyc > m_a) && (cyc <= m_end);
      chk("moving", 32'(moving), 32'(mv));
      chk("ready", 32'(cmd_ready), 32'(!mv));
      chk("start", 32'(start), 32'(cyc == m_start));
      chk("done", 32'(done), 32'(cyc == m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("position", 32'(position), 32'(m_pos[POS_W-1:0]));
      if (m_start >= 0 && cyc >= m_start && cyc <= m_end) begin
        chk("pulses", 32'(pulses), 32'(m_pulses));
        chk("dir", 32'(dir), 32'(m_dir));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    check_en  = 1'b0;
    rst       = 1'b1;
    drv_len   = 0;
    cmd_valid = 1'b0;
    zero      = 1'b0;
    repeat (n) step();
    rst       = 1'b0;
    m_pos     = 0;
    m_err     = 1'b0;
    m_a       = cyc - 1;
    m_end     = cyc - 1;
    m_start   = -1;
    m_done    = -1;
    m_upd_cyc = -1;
    m_eclr    = -1;
    m_eset    = -1;
    check_en  = 1'b1;
  endtask

  // zoff: cycle offset from accept at which i_zero is pulsed (-1 none);
  // roff: offset at which reset is applied (-1 none).
  task automatic send_cmd(input int tgt, input int dly, input int len, input int zoff,
                          input int roff);
    int t, d;
    t = clampv(tgt);
    d = t - m_pos;
    m_a       = cyc;
    m_eclr    = cyc + 1;
    m_eset    = -1;
    m_upd_cyc = -1;
    if (d == 0) begin
      m_start = -1;
      m_done  = cyc + 2;
      m_end   = cyc + 1;
    end else begin
      m_start  = cyc + 2;
      m_pulses = (d < 0) ? -d : d;
      m_dir    = (d > 0);
      if (len == 0 || dly + 1 > BT) begin
        m_end  = cyc + 2 + BT;
        m_eset = cyc + 3 + BT;
        m_done = -1;
      end else begin
        m_end     = cyc + 3 + dly + len;
        m_done    = m_end + 1;
        m_upd_cyc = m_done;
        m_upd_val = t;
      end
    end
    drv_dly    = dly;
    drv_len    = len;
    cmd_valid  = 1'b1;
    cmd_target = tgt[POS_W-1:0];
    zero       = (zoff == 0);
    step();
    cmd_valid  = 1'b0;
    cmd_target = 24'($urandom);
    while (cyc < m_end + 2) begin
      if (roff > 0 && cyc == m_a + roff) begin
        do_reset(1);
        return;
      end
      zero = (zoff > 0 && cyc == m_a + zoff);
      step();
    end
    zero = 1'b0;
  endtask

  task automatic zero_pulse();
    zero      = 1'b1;
    m_upd_cyc = cyc + 1;
    m_upd_val = 0;
    step();
    zero = 1'b0;
    step();
  endtask

  initial begin
    int ns;
    cmd_target = '0;
    do_reset(3);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_pulses", 32'(pulses), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_moving", 32'(moving), 32'd0);

    send_cmd(100, 1, 5, -1, -1);
    chk("p100_pulses", 32'(cap_pulses), 32'd100);
    chk("p100_dir", 32'(cap_dir), 32'd1);
    chk("p100_pos", 32'(position), 32'd100);

    send_cmd(-50, 0, 3, -1, -1);
    chk("m50_pulses", 32'(cap_pulses), 32'd150);
    chk("m50_dir", 32'(cap_dir), 32'd0);
    chk("m50_pos", 32'(position), 32'h00FF_FFCE);

    ns = n_start;
    send_cmd(-50, 2, 3, -1, -1);
    chk("zlen_nostart", 32'(n_start - ns), 32'd0);
    chk("zlen_pos", 32'(position), 32'h00FF_FFCE);

    send_cmd(77, 0, 0, -1, -1);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_pos", 32'(position), 32'h00FF_FFCE);

    send_cmd(77, 15, 4, -1, -1);
    chk("late_ok_error", 32'(error), 32'd0);
    chk("late_ok_pos", 32'(position), 32'd77);

    send_cmd(200, 16, 4, -1, -1);
    chk("too_late_error", 32'(error), 32'd1);
    chk("too_late_pos", 32'(position), 32'd77);
    repeat (8) step();

    send_cmd(40, 1, 3, 0, -1);
    chk("zero_vs_cmd_pos", 32'(position), 32'd40);
    send_cmd(-10, 1, 6, 4, -1);
    chk("zero_moving_pos", 32'(position), 32'h00FF_FFF6);
    zero_pulse();
    chk("zero_idle_pos", 32'(position), 32'd0);

    send_cmd(-8388608, 1, 2, -1, -1);
    chk("ext_min_pos", 32'(position), 32'h0080_0000);
    send_cmd(8388607, 1, 2, -1, -1);
`ifndef SOFT_LIMIT_EN
    chk("ext_pulses", 32'(cap_pulses), 32'h00FF_FFFF);
    chk("ext_dir", 32'(cap_dir), 32'd1);
    chk("ext_pos", 32'(position), 32'h007F_FFFF);
`endif

    zero_pulse();
    send_cmd(300, 2, 10, -1, 8);
    chk("midrst_pos", 32'(position), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_moving", 32'(moving), 32'd0);
    chk("midrst_pulses", 32'(pulses), 32'd0);
    repeat (12) step();

    send_cmd(5000, 1, 3, -1, -1);
`ifdef SOFT_LIMIT_EN
    chk("soft_pulses", 32'(cap_pulses), 32'd1000);
    chk("soft_pos", 32'(position), 32'd1000);
`else
    chk("soft_pulses", 32'(cap_pulses), 32'd5000);
    chk("soft_pos", 32'(position), 32'd5000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
